pc_ras_unit: RTL and testbench

- Next-generation fetch program counter for the core pipeline.
- Generalises the plain PC register with:
  - parametrised width and reset vector;
  - redirect from execute that takes priority over stall;
  - an internal return-address stack (RAS) for predicted returns.
- Sits at the front of IF. It feeds the instruction memory address and receives control from decode (call/return hints) and execute (resolved redirects).

---
 rtl/pc_ras_unit.sv | 88 ++++++++
 tb/tb_pc_ras_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// Fetch program counter with redirect, stall and a circular return-address stack.
// Latency: the selected next PC appears on PC one cycle after the qualifying edge; RetPredicted is combinational.
// Backpressure: Stall holds PC and RAS; RedirectValid overrides Stall; RasFlush empties the RAS on any edge.
module pc_ras_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       INC          = 4,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Stall,
    input  logic                           RedirectValid,
    input  logic [WIDTH-1:0]               RedirectTarget,
    input  logic                           CallValid,
    input  logic [WIDTH-1:0]               CallRetAddr,
    input  logic                           RetValid,
    input  logic                           RasFlush,
    output logic [WIDTH-1:0]               PC,
    output logic                           RetPredicted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    tp;
    logic [CW-1:0]    count;
    logic             upd;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] pc_next;

    assign upd          = !Stall && !RedirectValid;
    assign do_push      = upd && CallValid;
    assign do_pop       = upd && RetValid && (count != '0);
    assign RetPredicted = do_pop;
    assign RasCount     = count;

    always_comb begin
        pc_next = PC + WIDTH'(INC);
        if (RedirectValid) begin
            pc_next = {RedirectTarget[WIDTH-1:2], 2'b00};
        end else if (Stall) begin
            pc_next = PC;
        end else if (do_pop) begin
            pc_next = ras[tp];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC <= RESET_VECTOR;
        end else begin
            PC <= pc_next;
        end
    end

    // A simultaneous call and return swaps the top entry in place: tp and count stay put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp    <= '0;
            count <= '0;
        end else if (RasFlush) begin
            tp    <= '0;
            count <= '0;
        end else if (do_push && !do_pop) begin
            tp <= tp + PW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (do_pop && !do_push) begin
            tp    <= tp - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry contents need no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !RasFlush) begin
            if (do_pop) begin
                ras[tp] <= CallRetAddr;
            end else begin
                ras[tp + PW'(1)] <= CallRetAddr;
            end
        end
    end
endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Stall = 1'b0;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic        CallValid = 1'b0;
    logic [31:0] CallRetAddr = '0;
    logic        RetValid = 1'b0;
    logic        RasFlush = 1'b0;
    logic [31:0] PC;
    logic        RetPredicted;
    logic [2:0]  RasCount;

    int          n_pass = 0;
    int          n_total = 0;
    bit          mdl_on = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    bit          m_pred;
    logic [31:0] prev;

    pc_ras_unit #(
        .WIDTH(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .RedirectValid(RedirectValid),
        .RedirectTarget(RedirectTarget), .CallValid(CallValid), .CallRetAddr(CallRetAddr),
        .RetValid(RetValid), .RasFlush(RasFlush), .PC(PC), .RetPredicted(RetPredicted),
        .RasCount(RasCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: a LIFO queue capped at 4 entries, oldest dropped from the front.
    function automatic bit exp_pred();
        return !Stall && !RedirectValid && RetValid && (m_ras.size() > 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h100;
            m_ras.delete();
        end else begin
            m_pred = exp_pred();
            if (RedirectValid) m_pc = RedirectTarget & 32'hFFFF_FFFC;
            else if (!Stall) m_pc = m_pred ? m_ras[m_ras.size()-1] : m_pc + 32'd4;
            if (RasFlush) begin
                m_ras.delete();
            end else if (!Stall && !RedirectValid) begin
                if (CallValid && m_pred) begin
                    m_ras[m_ras.size()-1] = CallRetAddr;
                end else if (CallValid) begin
                    m_ras.push_back(CallRetAddr);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end else if (m_pred) begin
                    void'(m_ras.pop_back());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on && !rst) begin
            chk("mdl_pc", PC, m_pc);
            chk("mdl_count", {29'd0, RasCount}, m_ras.size());
            chk("mdl_retpred", {31'd0, RetPredicted}, {31'd0, exp_pred()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        Stall = 0; RedirectValid = 0; RedirectTarget = '0;
        CallValid = 0; CallRetAddr = '0; RetValid = 0; RasFlush = 0;
    endtask

    task automatic push(input logic [31:0] a);
        CallValid = 1; CallRetAddr = a;
        tick();
        CallValid = 0;
    endtask

    initial begin
        #2 rst = 1;
        #1 chk("rst_pc_initial", PC, 32'h100);
        tick();
        rst = 0;
        mdl_on = 1;
        tick(); tick(); tick();
        chk("seq_pre_rst", PC, 32'h10C);
        rst = 1;
        #2 chk("rst_midcycle_pc", PC, 32'h100);
        chk("rst_count", {29'd0, RasCount}, 32'd0);
        chk("rst_retpred", {31'd0, RetPredicted}, 32'd0);
        tick();
        rst = 0;
        tick(); chk("seq_1", PC, 32'h104);
        tick(); chk("seq_2", PC, 32'h108);
        tick(); chk("seq_3", PC, 32'h10C);

        Stall = 1;
        tick(); chk("stall_1", PC, 32'h10C);
        tick(); chk("stall_2", PC, 32'h10C);
        RedirectValid = 1; RedirectTarget = 32'h2003;
        tick(); chk("redirect_over_stall", PC, 32'h2000);
        clear_in();

        push(32'h40); push(32'h80);
        chk("call_count2", {29'd0, RasCount}, 32'd2);
        RetValid = 1;
        #1 chk("ret_pred_comb", {31'd0, RetPredicted}, 32'd1);
        tick(); chk("ret1_pc", PC, 32'h80); chk("ret1_count", {29'd0, RasCount}, 32'd1);
        tick(); chk("ret2_pc", PC, 32'h40); chk("ret2_count", {29'd0, RasCount}, 32'd0);
        RetValid = 0;

        push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
        chk("ovf_count", {29'd0, RasCount}, 32'd4);
        RetValid = 1;
        tick(); chk("ovf_pop1", PC, 32'h50);
        tick(); chk("ovf_pop2", PC, 32'h40);
        tick(); chk("ovf_pop3", PC, 32'h30);
        tick(); chk("ovf_pop4", PC, 32'h20);
        #1 chk("underflow_pred", {31'd0, RetPredicted}, 32'd0);
        prev = PC;
        tick(); chk("underflow_seq", PC, prev + 32'd4);
        RetValid = 0;

        push(32'h70);
        CallValid = 1; CallRetAddr = 32'h90; RetValid = 1;
        tick(); chk("swap_pc", PC, 32'h70); chk("swap_count", {29'd0, RasCount}, 32'd1);
        CallValid = 0;
        tick(); chk("swap_pop_pc", PC, 32'h90);
        RetValid = 0;
        push(32'hA0);
        CallValid = 1; CallRetAddr = 32'h55; RasFlush = 1;
        tick(); chk("flush_with_call", {29'd0, RasCount}, 32'd0);
        clear_in();

        RedirectValid = 1; RedirectTarget = 32'hFFFF_FFFF;
        tick(); chk("wrap_setup", PC, 32'hFFFF_FFFC);
        RedirectValid = 0;
        tick(); chk("wrap_pc", PC, 32'h0000_0000);

        for (int i = 0; i < 3000; i++) begin
            Stall          = ($urandom_range(0, 4) == 0);
            RedirectValid  = ($urandom_range(0, 9) == 0);
            RedirectTarget = $urandom;
            CallValid      = ($urandom_range(0, 2) == 0);
            CallRetAddr    = $urandom;
            RetValid       = ($urandom_range(0, 2) == 0);
            RasFlush       = !Stall && !RedirectValid && ($urandom_range(0, 29) == 0);
            tick();
        end
        clear_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
